// File: rtl/addsub_result_checker.sv
// -----------------------------------------------------------------------------
// addsub_result_checker
//
// In-circuit monitor for a WIDTH-bit ripple-carry adder/subtractor. The same
// operands and mode that drive the adder also drive this block. The block
// computes the golden sum/carry and delays it to line up with the adder's
// result latency. It then compares the two and keeps statistics that can be
// read back on a board with no simulator.
//
// Parameters
//   WIDTH    operand / sum width
//   LATENCY  cycles from in_valid to the adder result being valid (0..7)
//   CNT_W    width of the pass / fail / index counters
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid            operand vector presented this cycle
//   in_a, in_b, in_sub  operands and mode (0 = add, 1 = subtract)
//   dut_s, dut_cout     adder sum and carry-out under test
//   clear               synchronous clear of all statistics and the pipeline
//   pass_cnt, fail_cnt  saturating match / mismatch counters
//   vec_idx             saturating count of compared vectors
//   err_sticky          set by any mismatch until clear or reset
//   ff_*                capture of the first failing vector (ff_valid = held)
// -----------------------------------------------------------------------------
module addsub_result_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vec_idx,
  output logic             err_sticky,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_idx,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_sub,
  output logic [WIDTH-1:0] ff_s,
  output logic             ff_cout
);

  // Everything the compare stage needs to know about one vector.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] exp_s;
    logic             exp_cout;
  } pay_t;

  // First-fail capture record.
  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             cout;
  } ff_t;

  // ---------------------------------------------------------------------------
  // Golden model: a + b, or a + ~b + 1, at WIDTH+1 bits. In subtract mode the
  // top bit is the "no borrow" flag, i.e. 1 iff a >= b unsigned.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   golden;
  pay_t             in_pay;

  always_comb begin
    b_op   = in_sub ? ~in_b : in_b;
    golden = {1'b0, in_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, in_sub};
    in_pay = '{a: in_a, b: in_b, sub: in_sub,
               exp_s: golden[WIDTH-1:0], exp_cout: golden[WIDTH]};
  end

  // ---------------------------------------------------------------------------
  // Alignment pipeline. cmp_valid / cmp_pay describe the vector whose adder
  // result is on dut_s / dut_cout in the current cycle.
  // ---------------------------------------------------------------------------
  logic cmp_valid;
  pay_t cmp_pay;

  if (LATENCY == 0) begin : g_lat0
    assign cmp_valid = in_valid;
    assign cmp_pay   = in_pay;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld_q;
    pay_t               pay_q [LATENCY];

    // Only the valid bits need reset or clear; a flushed payload is never looked at.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (clear) begin
        // Also drops an in_valid that arrives together with clear.
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // NOTE: the payload shift register has no reset on purpose. The valid bits
    // gate every use of it, and leaving the reset off keeps the flops small.
    always_ff @(posedge clk) begin
      pay_q[0] <= in_pay;
      for (int i = 1; i < LATENCY; i++) begin
        pay_q[i] <= pay_q[i-1];
      end
    end

    assign cmp_valid = vld_q[LATENCY-1];
    assign cmp_pay   = pay_q[LATENCY-1];
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] idx_q,  idx_d;
  logic             err_q,  err_d;
  ff_t              ff_q,   ff_d;
  logic             match;

  assign match = (dut_s == cmp_pay.exp_s) && (dut_cout == cmp_pay.exp_cout);

  // NOTE: every _d starts from its _q value, so each path through the block
  // assigns every signal and no latch is inferred.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    idx_d  = idx_q;
    err_d  = err_q;
    ff_d   = ff_q;
    if (clear) begin
      // A compare in the same cycle as clear is discarded.
      pass_d = '0;
      fail_d = '0;
      idx_d  = '0;
      err_d  = 1'b0;
      ff_d   = '0;
    end else if (cmp_valid) begin
      idx_d = sat_inc(idx_q);
      if (match) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        err_d  = 1'b1;
        if (!ff_q.valid) begin
          ff_d = '{valid: 1'b1, idx: idx_q, a: cmp_pay.a, b: cmp_pay.b,
                   sub: cmp_pay.sub, s: dut_s, cout: dut_cout};
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only. Blocking
  // assignments here would let the simulation order of processes decide
  // which value other blocks see.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      fail_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      ff_q   <= '0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
    end
  end

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign vec_idx    = idx_q;
  assign err_sticky = err_q;
  assign ff_valid   = ff_q.valid;
  assign ff_idx     = ff_q.idx;
  assign ff_a       = ff_q.a;
  assign ff_b       = ff_q.b;
  assign ff_sub     = ff_q.sub;
  assign ff_s       = ff_q.s;
  assign ff_cout    = ff_q.cout;

endmodule

// File: tb/tb_addsub_result_checker.sv
// -----------------------------------------------------------------------------
// tb_addsub_result_checker
//
// Four checker instances share one stimulus stream:
//   u0  LATENCY=0, CNT_W=8 : adder result driven by the bench, faults injectable
//   u2  LATENCY=2          : adder result delayed by 1 or 2 registers (dly2)
//   u3  LATENCY=3          : adder result delayed by 3 registers
//   us  LATENCY=0, CNT_W=2 : saturation behaviour
// -----------------------------------------------------------------------------
module tb_addsub_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a, in_b;
  logic       in_sub;
  logic       clear;
  logic [3:0] dut0_s;
  logic       dut0_cout;
  int         dly2;

  always #5 clk = ~clk;

  // Reference adder: plain arithmetic. Returns {cout, sum}.
  function automatic logic [4:0] gold(input logic [3:0] a, input logic [3:0] b,
                                      input logic sub);
    int r;
    if (sub) begin
      r = (int'(a) - int'(b) + 16) % 16;
      return {(a >= b), r[3:0]};
    end
    r = int'(a) + int'(b);
    return {(r >= 16), r[3:0]};
  endfunction

  // Delayed copies of a correct adder.
  logic [4:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= gold(in_a, in_b, in_sub);
    p2 <= p1;
    p3 <= p2;
  end
  logic [4:0] dut2, dut_ok;
  assign dut2   = (dly2 == 2) ? p2 : p1;
  assign dut_ok = gold(in_a, in_b, in_sub);

  // ---- u0 -------------------------------------------------------------------
  logic [7:0] o0_pass, o0_fail, o0_idx, o0_ffidx;
  logic       o0_err, o0_ffv, o0_ffsub, o0_ffcout;
  logic [3:0] o0_ffa, o0_ffb, o0_ffs;

  addsub_result_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .dut_s(dut0_s), .dut_cout(dut0_cout), .clear(clear),
    .pass_cnt(o0_pass), .fail_cnt(o0_fail), .vec_idx(o0_idx),
    .err_sticky(o0_err), .ff_valid(o0_ffv), .ff_idx(o0_ffidx), .ff_a(o0_ffa),
    .ff_b(o0_ffb), .ff_sub(o0_ffsub), .ff_s(o0_ffs), .ff_cout(o0_ffcout));

  // ---- u2 -------------------------------------------------------------------
  logic [7:0] o2_pass, o2_fail, o2_idx, o2_ffidx;
  logic       o2_err, o2_ffv, o2_ffsub, o2_ffcout;
  logic [3:0] o2_ffa, o2_ffb, o2_ffs;

  addsub_result_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .dut_s(dut2[3:0]), .dut_cout(dut2[4]), .clear(clear),
    .pass_cnt(o2_pass), .fail_cnt(o2_fail), .vec_idx(o2_idx),
    .err_sticky(o2_err), .ff_valid(o2_ffv), .ff_idx(o2_ffidx), .ff_a(o2_ffa),
    .ff_b(o2_ffb), .ff_sub(o2_ffsub), .ff_s(o2_ffs), .ff_cout(o2_ffcout));

  // ---- u3 -------------------------------------------------------------------
  logic [7:0] o3_pass, o3_fail, o3_idx, o3_ffidx;
  logic       o3_err, o3_ffv, o3_ffsub, o3_ffcout;
  logic [3:0] o3_ffa, o3_ffb, o3_ffs;

  addsub_result_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .dut_s(p3[3:0]), .dut_cout(p3[4]), .clear(clear),
    .pass_cnt(o3_pass), .fail_cnt(o3_fail), .vec_idx(o3_idx),
    .err_sticky(o3_err), .ff_valid(o3_ffv), .ff_idx(o3_ffidx), .ff_a(o3_ffa),
    .ff_b(o3_ffb), .ff_sub(o3_ffsub), .ff_s(o3_ffs), .ff_cout(o3_ffcout));

  // ---- us -------------------------------------------------------------------
  logic [1:0] os_pass, os_fail, os_idx, os_ffidx;
  logic       os_err, os_ffv, os_ffsub, os_ffcout;
  logic [3:0] os_ffa, os_ffb, os_ffs;

  addsub_result_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .dut_s(dut_ok[3:0]), .dut_cout(dut_ok[4]), .clear(clear),
    .pass_cnt(os_pass), .fail_cnt(os_fail), .vec_idx(os_idx),
    .err_sticky(os_err), .ff_valid(os_ffv), .ff_idx(os_ffidx), .ff_a(os_ffa),
    .ff_b(os_ffb), .ff_sub(os_ffsub), .ff_s(os_ffs), .ff_cout(os_ffcout));

  // ---- helpers --------------------------------------------------------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector with an explicit adder result on u0's DUT inputs.
  task automatic drive_raw(input logic [3:0] a, input logic [3:0] b, input logic sub,
                           input logic [3:0] s, input logic c);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    dut0_s    = s;
    dut0_cout = c;
    tick();
  endtask

  // Present one vector; u0's adder result is the reference XOR a fault mask.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input logic [4:0] flip);
    logic [4:0] r;
    r = gold(a, b, sub) ^ flip;
    drive_raw(a, b, sub, r[3:0], r[4]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] es;
    logic       ec;
  } tv_t;

  tv_t tbl [6];

  // Random-phase scoreboard for u0.
  int         m_pass, m_fail, m_idx, m_err, m_ffv, m_ffidx, m_ffa, m_ffb;
  int         m_ffsub, m_ffs, m_ffc, n_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    clear = 1'b0; dut0_s = '0; dut0_cout = 1'b0; dly2 = 2;

    tbl[0] = '{4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[2] = '{4'b0110, 4'b0011, 1'b1, 4'b0011, 1'b1};
    tbl[3] = '{4'b0011, 4'b1000, 1'b1, 4'b1011, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1};

    // ---- reset state ----
    #12;
    check("reset pass_cnt", o0_pass, 0);
    check("reset fail_cnt", o0_fail, 0);
    check("reset vec_idx", o0_idx, 0);
    check("reset err_sticky", o0_err, 0);
    check("reset ff_valid", o0_ffv, 0);
    #4 rst_n = 1'b1;
    tick();

    // ---- table: correct adder, LATENCY=0 ----
    for (int i = 0; i < 6; i++) begin
      drive_raw(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].es, tbl[i].ec);
      check($sformatf("table pass_cnt v%0d", i), o0_pass, i + 1);
    end
    idle(1);
    check("table fail_cnt", o0_fail, 0);
    check("table err_sticky", o0_err, 0);
    check("table vec_idx", o0_idx, 6);

    // ---- fault injection: 3rd vector has carry forced to 0 ----
    do_clear();
    check("clear pass_cnt", o0_pass, 0);
    check("clear vec_idx", o0_idx, 0);
    drive(4'b0011, 4'b0001, 1'b0, 5'b0);
    drive(4'b0110, 4'b0011, 1'b1, 5'b0);
    drive_raw(4'b1000, 4'b0111, 1'b1, 4'b0001, 1'b0);
    idle(1);
    check("fault fail_cnt", o0_fail, 1);
    check("fault pass_cnt", o0_pass, 2);
    check("fault err_sticky", o0_err, 1);
    check("fault ff_valid", o0_ffv, 1);
    check("fault ff_idx", o0_ffidx, 2);
    check("fault ff_a", o0_ffa, 8);
    check("fault ff_b", o0_ffb, 7);
    check("fault ff_sub", o0_ffsub, 1);
    check("fault ff_s", o0_ffs, 1);
    check("fault ff_cout", o0_ffcout, 0);
    drive(4'b0001, 4'b0001, 1'b0, 5'b00001);
    idle(1);
    check("fault2 fail_cnt", o0_fail, 2);
    check("fault2 ff_idx held", o0_ffidx, 2);
    check("fault2 ff_a held", o0_ffa, 8);
    check("fault2 ff_s held", o0_ffs, 1);
    check("fault2 vec_idx", o0_idx, 4);

    // ---- clear coincident with a compare ----
    clear = 1'b1;
    drive(4'b0010, 4'b0010, 1'b0, 5'b0);
    clear = 1'b0;
    check("clr+cmp pass_cnt", o0_pass, 0);
    check("clr+cmp fail_cnt", o0_fail, 0);
    check("clr+cmp vec_idx", o0_idx, 0);
    check("clr+cmp err_sticky", o0_err, 0);
    check("clr+cmp ff_valid", o0_ffv, 0);
    check("clr+cmp ff_a", o0_ffa, 0);
    drive(4'b0101, 4'b0010, 1'b1, 5'b0);
    idle(1);
    check("after clr vec_idx", o0_idx, 1);
    check("after clr pass_cnt", o0_pass, 1);

    // ---- LATENCY=2, matching delay ----
    do_clear();
    dly2 = 2;
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 4'(i ^ 5), 1'(i & 1), 5'b0);
      if (i == 0) check("lat2 no early compare", o2_idx, 0);
    end
    idle(3);
    check("lat2 pass_cnt", o2_pass, 10);
    check("lat2 fail_cnt", o2_fail, 0);
    check("lat2 vec_idx", o2_idx, 10);

    // ---- LATENCY=2 against a 1-cycle adder ----
    do_clear();
    dly2 = 1;
    for (int i = 0; i < 10; i++) drive(4'(i), 4'(3), 1'b0, 5'b0);
    idle(3);
    check("lat2 wrong delay fails", int'(o2_fail > 0), 1);
    check("lat2 wrong delay err", o2_err, 1);
    dly2 = 2;

    // ---- clear flushes vectors in flight ----
    do_clear();
    drive(4'd1, 4'd2, 1'b0, 5'b0);
    drive(4'd3, 4'd4, 1'b0, 5'b0);
    do_clear();
    idle(4);
    check("flush u2 vec_idx", o2_idx, 0);
    check("flush u3 vec_idx", o3_idx, 0);

    // ---- saturation with CNT_W=2 ----
    do_clear();
    for (int i = 0; i < 5; i++) drive(4'(i + 2), 4'(i), 1'b1, 5'b0);
    idle(1);
    check("sat pass_cnt", os_pass, 3);
    check("sat vec_idx", os_idx, 3);
    check("sat fail_cnt", os_fail, 0);
    check("sat u0 unsaturated", o0_pass, 5);

    // ---- async reset with vectors in flight (LATENCY=3) ----
    do_clear();
    drive(4'd7, 4'd1, 1'b0, 5'b0);
    drive(4'd9, 4'd9, 1'b1, 5'b0);
    in_valid = 1'b0;
    check("pre-reset u0 pass_cnt", o0_pass, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset u0 pass_cnt", o0_pass, 0);
    check("async reset u0 vec_idx", o0_idx, 0);
    check("async reset u3 vec_idx", o3_idx, 0);
    #3 rst_n = 1'b1;
    idle(5);
    check("no stale u3 vec_idx", o3_idx, 0);
    check("no stale u3 pass_cnt", o3_pass, 0);

    // ---- randomized run against the scoreboard ----
    do_clear();
    m_pass = 0; m_fail = 0; m_idx = 0; m_err = 0; m_ffv = 0; m_ffidx = 0;
    m_ffa = 0; m_ffb = 0; m_ffsub = 0; m_ffs = 0; m_ffc = 0; n_valid = 0;
    for (int i = 0; i < 80; i++) begin
      logic       v, sub;
      logic [3:0] a, b;
      logic [4:0] flip, r;
      v    = ($urandom_range(0, 3) != 0);
      a    = 4'($urandom_range(0, 15));
      b    = 4'($urandom_range(0, 15));
      sub  = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      r    = gold(a, b, sub) ^ flip;
      if (v) begin
        n_valid++;
        if (flip == 0) begin
          m_pass++;
        end else begin
          m_fail++;
          m_err = 1;
          if (m_ffv == 0) begin
            m_ffv = 1; m_ffidx = m_idx; m_ffa = a; m_ffb = b;
            m_ffsub = sub; m_ffs = r[3:0]; m_ffc = r[4];
          end
        end
        m_idx++;
        drive_raw(a, b, sub, r[3:0], r[4]);
      end else begin
        idle(1);
      end
      check($sformatf("rnd pass_cnt c%0d", i), o0_pass, m_pass);
      check($sformatf("rnd fail_cnt c%0d", i), o0_fail, m_fail);
      check($sformatf("rnd vec_idx c%0d", i), o0_idx, m_idx);
    end
    idle(4);
    check("rnd err_sticky", o0_err, m_err);
    check("rnd ff_valid", o0_ffv, m_ffv);
    check("rnd ff_idx", o0_ffidx, m_ffidx);
    check("rnd ff_a", o0_ffa, m_ffa);
    check("rnd ff_b", o0_ffb, m_ffb);
    check("rnd ff_sub", o0_ffsub, m_ffsub);
    check("rnd ff_s", o0_ffs, m_ffs);
    check("rnd ff_cout", o0_ffcout, m_ffc);
    check("rnd u2 pass_cnt", o2_pass, n_valid);
    check("rnd u3 pass_cnt", o3_pass, n_valid);
    check("rnd u3 fail_cnt", o3_fail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run is short; anything beyond this is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
